// File: rtl/univ_reg_pkg.sv
// ----------------------------------------------------------------------------
// univ_reg_pkg
//   Shared definitions for the universal register (univ_reg) and its
//   next-state logic (univ_reg_next). Holds the 3-bit operation encodings
//   used on the op port.
//
//   Contents:
//     OP_HOLD .. OP_DEC  3-bit op select constants
//     OP_W               width of the op field
// ----------------------------------------------------------------------------
package univ_reg_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;  // q <= q
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;  // q <= d
    localparam logic [OP_W-1:0] OP_SHL  = 3'b010;  // shift left, sin_l enters bit 0
    localparam logic [OP_W-1:0] OP_SHR  = 3'b011;  // shift right, sin_r enters MSB
    localparam logic [OP_W-1:0] OP_ROL  = 3'b100;  // rotate left
    localparam logic [OP_W-1:0] OP_ROR  = 3'b101;  // rotate right
    localparam logic [OP_W-1:0] OP_INC  = 3'b110;  // q <= q + 1 (mod 2^WIDTH)
    localparam logic [OP_W-1:0] OP_DEC  = 3'b111;  // q <= q - 1 (mod 2^WIDTH)

endpackage : univ_reg_pkg

// File: rtl/univ_reg_next.sv
// ----------------------------------------------------------------------------
// univ_reg_next
//   Purely combinational next-state logic for univ_reg. Given the current
//   register value and the operation select it produces the value the
//   register takes when enabled, plus the next value of the wrap flag.
//   Enable and clear priority are handled by the caller.
//
//   Ports:
//     q          in   WIDTH  current register contents
//     d          in   WIDTH  parallel load data
//     op         in   3      operation select (see univ_reg_pkg)
//     sin_l      in   1      serial bit entering bit 0 on SHL
//     sin_r      in   1      serial bit entering bit WIDTH-1 on SHR
//     q_next     out  WIDTH  next register value
//     wrap_next  out  1      1 when INC from all-ones or DEC from zero
// ----------------------------------------------------------------------------
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic [OP_W-1:0]  op,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next
);

    logic q_all_ones;
    logic q_is_zero;

    assign q_all_ones = &q;
    assign q_is_zero  = ~|q;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        case (op)
            OP_HOLD: q_next = q;
            OP_LOAD: q_next = d;
            OP_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            OP_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            OP_INC: begin
                // Natural WIDTH-bit overflow gives the modulo behaviour.
                q_next    = q + WIDTH'(1);
                wrap_next = q_all_ones;
            end
            OP_DEC: begin
                q_next    = q - WIDTH'(1);
                wrap_next = q_is_zero;
            end
            default: begin
                q_next    = q;
                wrap_next = 1'b0;
            end
        endcase
    end

endmodule : univ_reg_next

// File: rtl/univ_reg.sv
// ----------------------------------------------------------------------------
// univ_reg
//   WIDTH-bit universal register: hold, parallel load, shift left/right with
//   serial inputs, rotate left/right, increment and decrement, with a
//   synchronous clear, a synchronous enable and an asynchronous active-low
//   reset to RESET_VAL.
//
//   Priority at each rising clk edge: clr, then en, then op.
//
//   Ports:
//     clk      in   1      rising-edge clock
//     reset_n  in   1      asynchronous active-low reset (q <= RESET_VAL)
//     en       in   1      synchronous enable; 0 holds q
//     clr      in   1      synchronous clear to 0, overrides en/op
//     op       in   3      operation select (see univ_reg_pkg)
//     d        in   WIDTH  parallel load data
//     sin_l    in   1      serial input for shift-left
//     sin_r    in   1      serial input for shift-right
//     q        out  WIDTH  register contents
//     sout_l   out  1      q[WIDTH-1]
//     sout_r   out  1      q[0]
//     zero     out  1      q == 0 (combinational)
//     wrap     out  1      registered; pulses after INC from all-ones or
//                          DEC from zero
// ----------------------------------------------------------------------------
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic             wrap
);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    univ_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q         (q_r),
        .d         (d),
        .op        (op),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q_next    (q_next),
        .wrap_next (wrap_next)
    );

    // State flops. wrap is only ever a one-cycle pulse: any edge that does
    // not perform a wrapping INC/DEC drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r    <= RESET_VAL;
            wrap_r <= 1'b0;
        end else if (clr) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else if (!en) begin
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next;
            wrap_r <= wrap_next;
        end
    end

    assign q      = q_r;
    assign wrap   = wrap_r;
    assign sout_l = q_r[WIDTH-1];
    assign sout_r = q_r[0];
    assign zero   = ~|q_r;

endmodule : univ_reg

// File: tb/tb_univ_reg.sv
// ----------------------------------------------------------------------------
// tb_univ_reg
//   Self-checking bench for univ_reg (WIDTH=8). A behavioural model built
//   from plain arithmetic tracks the expected register contents; a compare
//   process checks every output on each falling edge. Directed sequences pin
//   the model with literal expectations, then randomized traffic (including
//   asynchronous reset pulses) exercises the rest. A second instance with
//   RESET_VAL=0 covers the zero flag after reset.
// ----------------------------------------------------------------------------
module tb_univ_reg;
    import univ_reg_pkg::*;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         clr;
    logic [2:0]   op;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;

    logic [W-1:0] q;
    logic         sout_l, sout_r, zero, wrap;
    logic [W-1:0] q0;
    logic         sout_l0, sout_r0, zero0, wrap0;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    logic [7:0] m_q;
    logic       m_wrap;

    univ_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .op(op), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .zero(zero), .wrap(wrap)
    );

    univ_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .op(op), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q0), .sout_l(sout_l0),
        .sout_r(sout_r0), .zero(zero0), .wrap(wrap0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour expressed as integer arithmetic on the value.
    function automatic int model_next(int cur, int o, int dd, int sl, int sr);
        case (o)
            0: return cur;
            1: return dd;
            2: return (cur * 2 + sl) % 256;
            3: return cur / 2 + sr * 128;
            4: return (cur * 2) % 256 + cur / 128;
            5: return cur / 2 + (cur % 2) * 128;
            6: return (cur + 1) % 256;
            default: return (cur + 255) % 256;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q    <= RV;
            m_wrap <= 1'b0;
        end else if (clr) begin
            m_q    <= 8'd0;
            m_wrap <= 1'b0;
        end else if (!en) begin
            m_wrap <= 1'b0;
        end else begin
            m_q    <= 8'(model_next(int'(m_q), int'(op), int'(d), int'(sin_l), int'(sin_r)));
            m_wrap <= (op == OP_INC && int'(m_q) == 255) || (op == OP_DEC && int'(m_q) == 0);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cmp_q", q, m_q);
            chk("cmp_wrap", wrap, m_wrap);
            chk("cmp_sout_l", sout_l, (int'(m_q) >= 128));
            chk("cmp_sout_r", sout_r, (int'(m_q) % 2));
            chk("cmp_zero", zero, (int'(m_q) == 0));
        end
    end

    task automatic apply(input logic e, input logic c, input logic [2:0] o,
                         input logic [7:0] dd, input logic sl, input logic sr);
        @(negedge clk);
        en = e; clr = c; op = o; d = dd; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        apply(1'b1, 1'b0, OP_LOAD, v, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b1; en = 1'b0; clr = 1'b0; op = OP_HOLD;
        d = '0; sin_l = 1'b0; sin_r = 1'b0;

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        chk("rst_q", q, 8'hA5);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst0_q", q0, 8'h00);
        chk("rst0_zero", zero0, 1'b1);
        chk("rst0_wrap", wrap0, 1'b0);
        chk("rst0_sout_l", sout_l0, 1'b0);
        chk("rst0_sout_r", sout_r0, 1'b0);
        checking = 1;
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Load / hold
        load(8'h3C);
        chk("load_q", q, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, OP_LOAD, 8'hFF, 1'b0, 1'b0);
            chk("hold_en0_q", q, 8'h3C);
        end

        // Shifts and rotates
        load(8'h81);
        apply(1'b1, 1'b0, OP_SHL, 8'h00, 1'b0, 1'b1);
        chk("shl_q", q, 8'h02);
        chk("shl_sout_l", sout_l, 1'b0);
        chk("shl_sout_r", sout_r, 1'b0);
        load(8'h81);
        apply(1'b1, 1'b0, OP_SHR, 8'h00, 1'b0, 1'b1);
        chk("shr_q", q, 8'hC0);
        chk("shr_sout_l", sout_l, 1'b1);
        load(8'h81);
        apply(1'b1, 1'b0, OP_ROL, 8'h00, 1'b0, 1'b0);
        chk("rol_q", q, 8'h03);
        chk("rol_sout_r", sout_r, 1'b1);
        load(8'h81);
        apply(1'b1, 1'b0, OP_ROR, 8'h00, 1'b0, 1'b0);
        chk("ror_q", q, 8'hC0);

        // Wrap on increment and decrement
        load(8'hFE);
        apply(1'b1, 1'b0, OP_INC, 8'h00, 1'b0, 1'b0);
        chk("inc1_q", q, 8'hFF);
        chk("inc1_wrap", wrap, 1'b0);
        apply(1'b1, 1'b0, OP_INC, 8'h00, 1'b0, 1'b0);
        chk("inc2_q", q, 8'h00);
        chk("inc2_wrap", wrap, 1'b1);
        chk("inc2_zero", zero, 1'b1);
        apply(1'b1, 1'b0, OP_DEC, 8'h00, 1'b0, 1'b0);
        chk("dec_q", q, 8'hFF);
        chk("dec_wrap", wrap, 1'b1);
        apply(1'b1, 1'b0, OP_HOLD, 8'h00, 1'b0, 1'b0);
        chk("wrap_pulse_q", q, 8'hFF);
        chk("wrap_pulse_end", wrap, 1'b0);

        // Clear priority
        load(8'h55);
        apply(1'b1, 1'b1, OP_INC, 8'h00, 1'b0, 1'b0);
        chk("clr_en1_q", q, 8'h00);
        chk("clr_en1_wrap", wrap, 1'b0);
        load(8'h55);
        apply(1'b0, 1'b1, OP_LOAD, 8'h77, 1'b0, 1'b0);
        chk("clr_en0_q", q, 8'h00);

        // Reset in the middle of an increment run
        load(8'h10);
        @(negedge clk);
        en = 1'b1; clr = 1'b0; op = OP_INC;
        #2 reset_n = 1'b0;
        #1 chk("midrst_q", q, 8'hA5);
        chk("midrst_wrap", wrap, 1'b0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 chk("midrst_first_edge", q, 8'hA6);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en    = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 15) == 0);
            op    = 3'($urandom_range(0, 7));
            d     = 8'($urandom);
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            // Bias toward the wrap boundaries so they are hit regularly.
            if ($urandom_range(0, 9) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 63) == 0) begin
                #2 reset_n = 1'b0;
                #1 chk("rnd_rst_q", q, 8'hA5);
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_univ_reg

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised WIDTH-bit universal register: the successor to the team's single-bit enabled D flip-flop.
- Keeps asynchronous reset and synchronous enable, and adds these operating modes:
  - parallel load, shift left/right with serial inputs, rotate left/right, increment, decrement;
  - synchronous clear;
  - a parametrised reset value.
- Used as a general state/data holder in datapaths: shift chains, counters, scratch registers.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value loaded on asynchronous reset; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset; the only reset in the block.
- en  input  1  synchronous enable; when 0 the register holds (clr still acts).
- clr  input  1  synchronous clear to 0; highest synchronous priority.
- op  input  3  operation select, encoding given under Behaviour.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input shifted into bit 0 on shift-left.
- sin_r  input  1  serial input shifted into bit WIDTH-1 on shift-right.
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1] (bit leaving on a left shift).
- sout_r  output  1  equals q[0] (bit leaving on a right shift).
- zero  output  1  1 when q == 0; combinational from q.
- wrap  output  1  registered; 1 for exactly one cycle after an inc from all-ones or a dec from zero.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset: reset_n low forces q = RESET_VAL and wrap = 0 immediately, independent of clk.
  - Deassertion is synchronous to the user's reset synchroniser and is not handled inside the block.
  - Reset asserted mid-operation discards the operation in progress; the first edge after release applies normally.
- Priority at each rising clk edge:
  - clr = 1: q <= 0 and wrap <= 0, regardless of en and op.
  - else en = 0: q holds and wrap <= 0.
  - else en = 1: q updates per op.
- op encoding, all q updates WIDTH bits, one-cycle latency:
  - 000 HOLD: q <= q.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_l}.
  - 011 SHR: q <= {sin_r, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 INC: q <= q + 1, modulo 2^WIDTH; wrap <= (q == all-ones).
  - 111 DEC: q <= q - 1, modulo 2^WIDTH; wrap <= (q == 0).
- wrap is 0 after every op other than INC/DEC, and is cleared by reset and by clr.
- sout_l, sout_r and zero are combinational from the current q, with no extra latency.
  - After reset, zero reflects RESET_VAL.
- Next-state logic is purely combinational and fully specified for all op values; no latches.

Decomposition:
- Package univ_reg_pkg holds the 3-bit op localparams OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_INC, OP_DEC.
  - Shared by RTL and bench.
- One sub-module, univ_reg_next:
  - combinational next-state and next-wrap logic from (q, d, op, sin_l, sin_r);
  - parametrised by WIDTH.
- The top univ_reg keeps only the state flops (q, wrap), the enable/clear priority and the output assigns.

Test Plan (WIDTH=8, RESET_VAL=8'hA5 unless noted):
- Reset: reset_n low between clock edges -> q = 8'hA5 and wrap = 0 immediately, without waiting for clk; zero = 0. Repeat with RESET_VAL=0 -> zero = 1.
- Load/hold: en=1, op=LOAD, d=8'h3C for one edge -> q=8'h3C. Then en=0, op=LOAD, d=8'hFF for 3 edges -> q stays 8'h3C.
- Shifts:
  - q=8'h81, SHL with sin_l=0 -> q=8'h02.
  - q=8'h81, SHR with sin_r=1 -> q=8'hC0.
  - q=8'h81, ROL -> q=8'h03; ROR from 8'h81 -> q=8'hC0.
  - sout_l/sout_r match q[7]/q[0] each cycle.
- Wrap:
  - q=8'hFE, INC x2 -> q=8'hFF with wrap=0, then q=8'h00 with wrap=1 for one cycle and zero=1.
  - DEC from 8'h00 -> q=8'hFF with wrap=1.
- Priority: q=8'h55, en=1, op=INC, clr=1 -> q=8'h00 and wrap=0. clr=1 with en=0 also clears.
- Reset mid-operation: INC running from 8'h10, reset_n pulsed low between edges -> q=8'hA5 immediately; the first edge after release gives q=8'hA6.
